// File: rtl/my_pkg.sv
// Shared types for the RV hazard unit: forwarding selects and MD tracker states.
package my_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_MD = 2'b01,
    FWD_W  = 2'b10,
    FWD_M  = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // Wide enough for MD_LAT up to 15.
  localparam int unsigned MD_CNT_W = 4;

endpackage

// File: rtl/rv_md_tracker.sv
// Multi-cycle (MUL/DIV) occupancy tracker: IDLE/BUSY FSM, latency down-counter,
// destination latch and a one-cycle writeback pulse.
module rv_md_tracker
  import my_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              busy_o,
  output logic              wb_o,
  output logic [REG_AW-1:0] md_rd_o
);

  md_state_t           state_q;
  logic [MD_CNT_W-1:0] cnt_q;
  logic                wb_q;
  logic [REG_AW-1:0]   rd_q;

  // The counter reaches 0 on the edge that leaves BUSY, so md_wb is a registered
  // pulse in the first IDLE cycle; an op issued in cycle c writes back in c+MD_LAT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      wb_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      wb_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            state_q <= MD_BUSY;
            cnt_q   <= MD_CNT_W'(MD_LAT - 1);
            rd_q    <= rd_i;
          end
        end
        MD_BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == MD_CNT_W'(1)) begin
            state_q <= MD_IDLE;
            wb_q    <= 1'b1;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q == MD_BUSY);
  assign wb_o    = wb_q;
  assign md_rd_o = rd_q;

endmodule

// File: rtl/rv_hazard_control_mc.sv
// Hazard control: forwarding selects plus load-use, branch and multi-cycle stall/flush.
// Optional macro RV_MD_SCOREBOARD_EN: while MD is busy, stall only dependent decode ops.
module rv_hazard_control_mc
  import my_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              mem_to_regE,
  input  logic              reg_writeM,
  input  logic              reg_writeW,
  input  logic              br_taken,
  input  logic              md_startE,
  output fwd_sel_t          forward_rs1E,
  output fwd_sel_t          forward_rs2E,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic              md_busy,
  output logic              md_wb
);

  logic [REG_AW-1:0] md_rd;
  logic              load_use;
  logic              stall_fd;
  logic              stall_e;
  logic              md_accept;

  rv_md_tracker #(
    .REG_AW (REG_AW),
    .MD_LAT (MD_LAT)
  ) u_md_tracker (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_accept),
    .rd_i    (rdE),
    .busy_o  (md_busy),
    .wb_o    (md_wb),
    .md_rd_o (md_rd)
  );

  // x0 never forwards; a zero md_rd is therefore excluded implicitly.
  function automatic fwd_sel_t fwd_sel(input logic [REG_AW-1:0] rs);
    if (rs == '0)                    return FWD_RF;
    if (md_wb && (rs == md_rd))      return FWD_MD;
    if (reg_writeM && (rs == rdM))   return FWD_M;
    if (reg_writeW && (rs == rdW))   return FWD_W;
    return FWD_RF;
  endfunction

  always_comb begin
    load_use = mem_to_regE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
`ifdef RV_MD_SCOREBOARD_EN
    stall_e  = md_busy && md_startE;
    stall_fd = load_use || stall_e ||
               (md_busy && (md_rd != '0) && ((rs1D == md_rd) || (rs2D == md_rd)));
`else
    stall_e  = md_busy;
    stall_fd = load_use || md_busy;
`endif
    forward_rs1E = FWD_RF;
    forward_rs2E = FWD_RF;
    stallF       = 1'b0;
    stallD       = 1'b0;
    stallE       = 1'b0;
    flushD       = 1'b0;
    flushE       = 1'b0;
    if (!rst) begin
      forward_rs1E = fwd_sel(rs1E);
      forward_rs2E = fwd_sel(rs2E);
      if (br_taken) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else begin
        stallF = stall_fd;
        stallD = stall_fd;
        stallE = stall_e;
        flushE = load_use;
      end
    end
  end

  // A branch squashes the E-stage op, so it must not start the MD unit.
  assign md_accept = md_startE && !stallE && !br_taken;

endmodule

// File: doc/rv_hazard_control_mc.md
RV_HAZARD_CONTROL_MC -- requirements
Module: rv_hazard_control_mc

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MD_LAT, default 4, multi-cycle (MUL/DIV) unit latency in cycles, legal range 2..15.
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports rs1D, rs2D, rs1E, rs2E  input  REG_AW each  decode-stage and execute-stage source registers.
REQ-006 SHALL have ports rdE, rdM, rdW  input  REG_AW each  destination registers in E, M and W.
REQ-007 SHALL have ports mem_to_regE, reg_writeM, reg_writeW  input  1 each  load in E; M writes a register; W writes a register.
REQ-008 SHALL have port br_taken  input  1  branch mispredict resolved in E.
REQ-009 SHALL have port md_startE  input  1  multi-cycle op issuing from E with destination rdE.
REQ-010 SHALL have ports forward_rs1E, forward_rs2E  output  2 each  forwarding select of type fwd_sel_t.
REQ-011 SHALL have ports stallF, stallD, stallE, flushD, flushE  output  1 each  pipeline control.
REQ-012 SHALL have ports md_busy  output  1  and  md_wb  output  1  (one-cycle pulse when the MD result is valid for writeback).

Function
REQ-013 Forwarding select per source SHALL use the priority MD result (md_wb and rsE==md_rd) > M (reg_writeM and rsE==rdM) > W (reg_writeW and rsE==rdW) > register file; x0 always selects register file.
REQ-014 Load-use SHALL be detected as mem_to_regE, rdE!=0 and rdE equal to rs1D or rs2D; this asserts stallF, stallD and flushE for exactly one cycle.
REQ-015 br_taken SHALL assert flushD and flushE in the same cycle and SHALL override every stall (stallF=stallD=stallE=0).
REQ-016 The MD tracker SHALL have states IDLE and BUSY; IDLE->BUSY on md_startE with stallE=0 and br_taken=0, loading a down-counter with MD_LAT-1 and latching md_rd=rdE.
REQ-017 In BUSY the counter SHALL decrement each cycle; at value 0 it SHALL return to IDLE and assert md_wb for that one cycle.
REQ-018 md_busy SHALL equal (state==BUSY).
REQ-019 md_startE while BUSY SHALL assert stallF, stallD and stallE until the cycle md_wb is high; the new op is accepted in that same cycle (back-to-back, no idle gap).
REQ-020 br_taken while BUSY SHALL NOT cancel the in-flight MD op (it is older than the branch).
REQ-021 md_rd==0 SHALL still run the counter but SHALL never forward.
REQ-022 All outputs other than the MD tracker's SHALL be combinational on current inputs and state.

Reset
REQ-023 rst SHALL immediately force state IDLE, counter 0, md_rd 0, md_busy 0, md_wb 0.
REQ-024 Reset mid-BUSY SHALL discard the op with no md_wb pulse.
REQ-025 While rst is high all stall and flush outputs SHALL be 0 and forward selects FWD_RF.

Configuration
REQ-026 With RV_MD_SCOREBOARD_EN defined, BUSY SHALL stall F/D only when rs1D or rs2D equals a non-zero md_rd, or when REQ-019 applies; independent instructions proceed.
REQ-027 Without RV_MD_SCOREBOARD_EN, BUSY SHALL assert stallF, stallD and stallE on every cycle except the md_wb cycle.

Structure
REQ-028 my_pkg SHALL hold fwd_sel_t: FWD_RF=2'b00, FWD_MD=2'b01, FWD_W=2'b10, FWD_M=2'b11.
REQ-029 The state machine, counter and md_rd register SHALL live in sub-module rv_md_tracker; forwarding and stall/flush logic stays in the top.

Verification
REQ-030 rs1E=5, rdM=5, reg_writeM=1, rdW=5, reg_writeW=1 -> forward_rs1E=FWD_M; rs1E=0 with the same other inputs -> FWD_RF.
REQ-031 Load in E with rdE=7, rs2D=7 -> stallF=stallD=flushE=1 for exactly one cycle, then 0.
REQ-032 MD_LAT=4, md_startE with rdE=9 at cycle 0 -> md_busy high cycles 1-3, md_wb at cycle 4, forward_rs1E=FWD_MD when rs1E=9 in cycle 4.
REQ-033 Second md_startE at cycle 2 of a busy op -> stallE held until md_wb, new op accepted that cycle, next md_wb 4 cycles later.
REQ-034 br_taken together with load-use -> flushD=flushE=1 and stallF=stallD=0; rst asserted at BUSY cycle 2 -> md_busy=0 at once, no md_wb.
REQ-035 Scoreboard build: BUSY on rd=9 with rs1D=3 -> no stall; rs1D=9 -> stallF=stallD=1 until md_wb.
